paddle_state_tx: RTL
====================

Name: paddle_state_tx

Overview:
Transmit-side counterpart to the paddle keycode consumer. Once per frame tick, the block snapshots the local paddle position and the filtered movement keycode. It frames them into a 6-byte packet and streams that packet byte-wise over a valid/ready interface to the Ethernet MAC TX path, so the remote board can reproduce the paddle. The block sits between the local paddle/keyboard logic and the MAC byte FIFO.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame marker, packet byte 0
PAD_Y_MAX, 10'd479, largest legal paddle_y; larger values are clamped before framing

Ports:
Clk  input  1  system clock
Reset_n  input  1  asynchronous, active-low reset
frame_clk  input  1  vertical-sync frame tick, asynchronous to Clk; rising edge requests a packet
paddle_y  input  10  current local paddle centre Y
keycode  input  8  current local keycode
is_left  input  1  1 = this board drives the left paddle
tx_data  output  8  packet byte
tx_valid  output  1  tx_data holds a valid byte
tx_ready  input  1  downstream accepts the byte this cycle
tx_last  output  1  high with the final packet byte
busy  output  1  packet in flight (state SEND)
seq_out  output  8  sequence number that the next packet will carry
drop_cnt  output  8  saturating count of frame ticks dropped while busy

Behaviour:
- Reset (asynchronous, Reset_n=0) values: tx_valid=0, tx_last=0, tx_data=0, busy=0, seq_out=0, drop_cnt=0, state=IDLE, synchroniser flops=0. Reset mid-packet abandons the packet; no partial completion occurs after release.
- frame_clk path: 2-flop synchroniser, then a rising-edge detect gives a 1-cycle tick. The tick occurs on the 3rd Clk edge after frame_clk rises.
- Keycode filter: 8'h01 (W) and 8'h02 (S) pass unchanged; any other value is sent as 8'h00.
- paddle_y above PAD_Y_MAX is sent as PAD_Y_MAX.
- Packet bytes:
  - 0: SOF_BYTE
  - 1: {is_left, 5'b0, y[9:8]}
  - 2: y[7:0]
  - 3: filtered keycode
  - 4: seq
  - 5: check = XOR of bytes 0-4
- States: IDLE, SEND.
- IDLE, tick: snapshot y, keycode, is_left and seq into registers; byte index=0; check accumulator=0; go to SEND. tx_valid rises on the next edge (1-cycle latency tick->tx_valid).
- SEND: tx_valid=1 and tx_data=byte[index].
  - tx_data and tx_last must hold stable while tx_valid && !tx_ready.
  - On tx_valid && tx_ready: accumulator ^= tx_data and index++.
  - On acceptance of byte 5 (tx_last=1): tx_valid=0 next cycle, seq_out increments (255 wraps to 0), go to IDLE. A new tick may be accepted on the cycle immediately after return to IDLE.
- tick while SEND (including the cycle byte 5 is accepted): tick is dropped, not queued. drop_cnt increments, saturating at 255.
- Input changes during SEND do not affect the packet; only snapshot values are sent.
- tx_ready held low indefinitely: the block stalls on the current byte with no timeout.

Optional Feature:
PADDLE_TX_CRC8_EN
- Defined: byte 5 is CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over bytes 0-4, updated per accepted byte.
- Undefined: byte 5 is the XOR check.
- Framing, length and timing are identical in both cases.

Decomposition:
- Package paddle_pkt_pkg: PKT_LEN=6, SOF default, KEY_W=8'h01, KEY_S=8'h02, KEY_NONE=8'h00, byte-index typedef (3-bit), state enum {IDLE, SEND}, check-function selector.
- Sub-module paddle_pkt_check: per-byte accumulator (XOR, or CRC-8 under the macro). Inputs: clear, byte_en, data. Output: check byte. Reused by the future RX decoder.

Test Plan:
- Reset, then frame_clk rise with paddle_y=120, keycode=8'h01, is_left=1, tx_ready=1 -> bytes A5,80,78,01,00,5C; tx_last only on 5C; seq_out=1 afterwards.
- keycode=8'h1A, paddle_y=600, is_left=0 -> byte1=01, byte2=DF, byte3=00.
- tx_ready toggled 1,0,0,1 pseudo-randomly -> tx_data and tx_last stable during stalls; byte order unchanged; exactly 6 handshakes.
- Second frame_clk edge during SEND with tx_ready=0 -> drop_cnt=1, only one packet emitted. 300 dropped ticks -> drop_cnt=255.
- 256 packets -> 256th carries seq=FF, seq_out then 00.
- Reset_n low while byte 2 is pending -> tx_valid=0 immediately. After release plus one tick, the packet restarts at A5 with seq=00.
- With PADDLE_TX_CRC8_EN defined, same stimulus as the first scenario -> byte 5 equals the CRC-8 of A5,80,78,01,00 from the reference model.

Source files
------------

// File: rtl/paddle_pkt_pkg.sv
// Shared types and helpers for the paddle packet TX path and its future RX decoder.
// PADDLE_TX_CRC8_EN selects CRC-8 instead of XOR for the trailing check byte.
package paddle_pkt_pkg;
  localparam int         PKT_LEN     = 6;
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;
  localparam logic [7:0] KEY_W       = 8'h01;
  localparam logic [7:0] KEY_S       = 8'h02;
  localparam logic [7:0] KEY_NONE    = 8'h00;

  typedef logic [2:0] pkt_idx_t;
  localparam pkt_idx_t LAST_IDX = 3'(PKT_LEN - 1);

  typedef enum logic {IDLE, SEND} tx_state_t;
  typedef enum logic {CHK_XOR, CHK_CRC8} chk_sel_t;

`ifdef PADDLE_TX_CRC8_EN
  localparam chk_sel_t CHECK_SEL = CHK_CRC8;
`else
  localparam chk_sel_t CHECK_SEL = CHK_XOR;
`endif

  // CRC-8, poly 0x07, MSB first, no reflection
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  function automatic logic [7:0] key_filter(input logic [7:0] key);
    return (key == KEY_W || key == KEY_S) ? key : KEY_NONE;
  endfunction
endpackage

// File: rtl/paddle_pkt_check.sv
// Per-byte check accumulator: XOR by default, CRC-8 when PADDLE_TX_CRC8_EN is defined.
module paddle_pkt_check
  import paddle_pkt_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       clear,
  input  logic       byte_en,
  input  logic [7:0] data,
  output logic [7:0] check
);
  logic [7:0] acc_d;

  always_comb begin
    acc_d = check;
    if (clear)
      acc_d = 8'h00;
    else if (byte_en)
      acc_d = (CHECK_SEL == CHK_CRC8) ? crc8_step(check, data) : (check ^ data);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) check <= 8'h00;
    else          check <= acc_d;
  end
endmodule

// File: rtl/paddle_state_tx.sv
// Frames a per-frame paddle snapshot into a 6-byte packet streamed over valid/ready.
// Check byte kind follows PADDLE_TX_CRC8_EN (see paddle_pkt_pkg).
//   state | meaning
//   IDLE  | waiting for a synchronised frame tick
//   SEND  | streaming snapshot bytes 0..5, stalling on !tx_ready
module paddle_state_tx
  import paddle_pkt_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE  = SOF_DEFAULT,
  parameter logic [9:0] PAD_Y_MAX = 10'd479
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [9:0] paddle_y,
  input  logic [7:0] keycode,
  input  logic       is_left,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last,
  output logic       busy,
  output logic [7:0] seq_out,
  output logic [7:0] drop_cnt
);
  tx_state_t  state_q, state_d;
  pkt_idx_t   idx_q;
  logic [9:0] y_q;
  logic [7:0] key_q, seq_q, check;
  logic       left_q;
  logic       sync1, sync2, sync3, tick;
  logic       take, accept, last_accept;

  assign tick = sync2 & ~sync3;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) {sync1, sync2, sync3} <= 3'b000;
    else          {sync1, sync2, sync3} <= {frame_clk, sync1, sync2};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    take        = 1'b0;
    accept      = 1'b0;
    last_accept = 1'b0;
    case (state_q)
      IDLE: if (tick) begin
        take    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        accept = tx_ready;
        if (tx_ready && idx_q == LAST_IDX) begin
          last_accept = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = (state_q == SEND);
    busy     = (state_q == SEND);
    tx_last  = (state_q == SEND) && (idx_q == LAST_IDX);
    tx_data  = 8'h00;
    if (state_q == SEND) begin
      case (idx_q)
        3'd0:    tx_data = SOF_BYTE;
        3'd1:    tx_data = {left_q, 5'b0, y_q[9:8]};
        3'd2:    tx_data = y_q[7:0];
        3'd3:    tx_data = key_q;
        3'd4:    tx_data = seq_q;
        default: tx_data = check;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx_q    <= '0;
      y_q      <= '0;
      key_q    <= '0;
      seq_q    <= '0;
      left_q   <= 1'b0;
      seq_out  <= '0;
      drop_cnt <= '0;
    end else begin
      if (take) begin
        idx_q  <= '0;
        y_q    <= (paddle_y > PAD_Y_MAX) ? PAD_Y_MAX : paddle_y;
        key_q  <= key_filter(keycode);
        left_q <= is_left;
        seq_q  <= seq_out;
      end else if (accept) begin
        idx_q <= idx_q + 3'd1;
      end
      if (last_accept)
        seq_out <= seq_out + 8'd1;
      // ticks arriving mid-packet are counted, never queued
      if (tick && state_q == SEND && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  paddle_pkt_check u_check (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clear   (take),
    .byte_en (accept),
    .data    (tx_data),
    .check   (check)
  );
endmodule
